branch_predictor_2bit: RTL and testbench

//  Direct-mapped branch target buffer with a 2-bit saturating counter per entry.

---
 rtl/branch_predictor_2bit_if.sv | 27 ++
 rtl/branch_predictor_2bit.sv | 95 +++++++++
 tb/tb_branch_predictor_2bit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_2bit_if.sv
// Fetch-side lookup, MEM-side update and debug statistics of the 2-bit branch predictor.
// The predictor is the slave; the pipeline/monitor side is the master.
interface branch_predictor_2bit_if #(
  parameter int STAT_W = 16
);
  logic [31:0]       lk_pc;
  logic              lk_hit;
  logic              lk_taken;
  logic [31:0]       lk_next_pc;
  logic              upd_en;
  logic [31:0]       upd_pc;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic              upd_pred_taken;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispred;

  modport master (
    output lk_pc, upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken,
    input  lk_hit, lk_taken, lk_next_pc, stat_branches, stat_mispred
  );

  modport slave (
    input  lk_pc, upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken,
    output lk_hit, lk_taken, lk_next_pc, stat_branches, stat_mispred
  );
endinterface

// File: rtl/branch_predictor_2bit.sv
// Direct-mapped branch target buffer with 2-bit saturating counters, a same-cycle
// combinational lookup, a registered MEM-stage update and saturating statistics.
module branch_predictor_2bit #(
  parameter int         IDX_BITS = 4,
  parameter logic [1:0] CNT_INIT = 2'b10,
  parameter int         STAT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_predictor_2bit_if.slave bp
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 32 - IDX_BITS - 2;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [1:0]         r_cnt    [ENTRIES];
  logic [STAT_W-1:0]  r_branches;
  logic [STAT_W-1:0]  r_mispred;

  logic [IDX_BITS-1:0] w_lkIdx;
  logic [TAG_W-1:0]    w_lkTag;
  logic                w_lkHit;
  logic                w_lkTaken;
  logic [IDX_BITS-1:0] w_updIdx;
  logic [TAG_W-1:0]    w_updTag;
  logic                w_updHit;
  logic [1:0]          w_updCnt;
  logic [1:0]          w_cntInc;
  logic [1:0]          w_cntDec;
  logic                w_unused_pc_lsbs;

  assign w_lkIdx  = bp.lk_pc[IDX_BITS+1:2];
  assign w_lkTag  = bp.lk_pc[31:IDX_BITS+2];
  assign w_updIdx = bp.upd_pc[IDX_BITS+1:2];
  assign w_updTag = bp.upd_pc[31:IDX_BITS+2];
  assign w_unused_pc_lsbs = ^{bp.lk_pc[1:0], bp.upd_pc[1:0]};

  // Lookup reads the arrays as they stand this cycle; an update in the same cycle is not bypassed.
  assign w_lkHit   = r_valid[w_lkIdx] && (r_tag[w_lkIdx] == w_lkTag);
  assign w_lkTaken = w_lkHit && r_cnt[w_lkIdx][1];

  assign bp.lk_hit     = w_lkHit;
  assign bp.lk_taken   = w_lkTaken;
  assign bp.lk_next_pc = w_lkTaken ? r_target[w_lkIdx] : (bp.lk_pc + 32'd4);

  assign w_updHit = r_valid[w_updIdx] && (r_tag[w_updIdx] == w_updTag);
  assign w_updCnt = r_cnt[w_updIdx];
  assign w_cntInc = (w_updCnt == 2'b11) ? 2'b11 : (w_updCnt + 2'd1);
  assign w_cntDec = (w_updCnt == 2'b00) ? 2'b00 : (w_updCnt - 2'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (bp.upd_en && !w_updHit && bp.upd_taken) begin
      r_valid[w_updIdx] <= 1'b1;
    end
  end

  // Payload arrays are never reset; a write landing during reset stays hidden behind a cleared valid bit.
  always_ff @(posedge clk) begin
    if (bp.upd_en) begin
      if (w_updHit) begin
        if (bp.upd_taken) begin
          r_cnt[w_updIdx]    <= w_cntInc;
          r_target[w_updIdx] <= bp.upd_target;
        end else begin
          r_cnt[w_updIdx]    <= w_cntDec;
        end
      end else if (bp.upd_taken) begin
        r_tag[w_updIdx]    <= w_updTag;
        r_target[w_updIdx] <= bp.upd_target;
        r_cnt[w_updIdx]    <= CNT_INIT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branches <= '0;
      r_mispred  <= '0;
    end else if (bp.upd_en) begin
      if (r_branches != '1) begin
        r_branches <= r_branches + 1'b1;
      end
      if ((bp.upd_taken != bp.upd_pred_taken) && (r_mispred != '1)) begin
        r_mispred <= r_mispred + 1'b1;
      end
    end
  end

  assign bp.stat_branches = r_branches;
  assign bp.stat_mispred  = r_mispred;
endmodule

// File: tb/tb_branch_predictor_2bit.sv
// Scoreboard bench for branch_predictor_2bit: a driver pushes expectations from an
// entry-level reference model, a monitor pops and compares them every cycle.
module tb_branch_predictor_2bit;
  localparam int ENTRIES = 16;
  localparam int SATMAX  = 65535;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] nextPc;
    int          branches;
    int          mispred;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  exp_t expQ[$];
  int   checks;
  int   failures;

  // Reference model: per-entry owner word address, target and a counter kept as 0..3.
  bit          mValid  [ENTRIES];
  logic [29:0] mLine   [ENTRIES];
  logic [31:0] mTarget [ENTRIES];
  int          mCnt    [ENTRIES];
  int          mBranches;
  int          mMispred;

  branch_predictor_2bit_if #(.STAT_W(16)) bpIf ();

  branch_predictor_2bit #(
    .IDX_BITS (4),
    .CNT_INIT (2'b10),
    .STAT_W   (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bpIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int idxOf(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  function automatic logic modelHit(input logic [31:0] pc);
    return mValid[idxOf(pc)] && (mLine[idxOf(pc)] == pc[31:2]);
  endfunction

  function automatic logic modelTaken(input logic [31:0] pc);
    return modelHit(pc) && (mCnt[idxOf(pc)] >= 2);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstIn, input logic [31:0] lkPc, input logic en,
                               input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                               input logic pred, input string name);
    exp_t e;
    int   i;
    @(negedge clk);
    rst                   = rstIn;
    bpIf.lk_pc            = lkPc;
    bpIf.upd_en           = en;
    bpIf.upd_pc           = pc;
    bpIf.upd_taken        = tk;
    bpIf.upd_target       = tgt;
    bpIf.upd_pred_taken   = pred;
    if (rstIn) begin
      for (int k = 0; k < ENTRIES; k++) mValid[k] = 1'b0;
      mBranches = 0;
      mMispred  = 0;
    end
    e.hit      = modelHit(lkPc);
    e.taken    = modelTaken(lkPc);
    e.nextPc   = e.taken ? mTarget[idxOf(lkPc)] : lkPc + 32'd4;
    e.branches = mBranches;
    e.mispred  = mMispred;
    e.name     = name;
    expQ.push_back(e);
    if (!rstIn && en) begin
      i = idxOf(pc);
      if (modelHit(pc)) begin
        if (tk) begin
          mCnt[i]    = (mCnt[i] + 1 > 3) ? 3 : mCnt[i] + 1;
          mTarget[i] = tgt;
        end else begin
          mCnt[i] = (mCnt[i] - 1 < 0) ? 0 : mCnt[i] - 1;
        end
      end else if (tk) begin
        mValid[i]  = 1'b1;
        mLine[i]   = pc[31:2];
        mTarget[i] = tgt;
        mCnt[i]    = 2;
      end
      if (mBranches < SATMAX) mBranches++;
      if ((tk != pred) && (mMispred < SATMAX)) mMispred++;
    end
  endtask

  // Monitor samples mid-low-phase, after the driver has settled this cycle's inputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({e.name, ".hit"},      32'(bpIf.lk_hit),        32'(e.hit));
        checkOutput({e.name, ".taken"},    32'(bpIf.lk_taken),      32'(e.taken));
        checkOutput({e.name, ".next_pc"},  bpIf.lk_next_pc,         e.nextPc);
        checkOutput({e.name, ".branches"}, 32'(bpIf.stat_branches), 32'(e.branches));
        checkOutput({e.name, ".mispred"},  32'(bpIf.stat_mispred),  32'(e.mispred));
      end
    end
  end

  initial begin
    logic [31:0] pc;
    logic [31:0] lk;
    logic        tk;
    logic        pred;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bpIf.lk_pc = 32'h40;
    bpIf.upd_en = 1'b0;
    bpIf.upd_pc = '0;
    bpIf.upd_taken = 1'b0;
    bpIf.upd_target = '0;
    bpIf.upd_pred_taken = 1'b0;

    applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, "reset");
    applyStimulus(0, 32'h40, 0, 0, 0, 0, 0, "post_reset");
    applyStimulus(0, 32'h40, 1, 32'h40, 1, 32'h80, 0, "alloc_same_cycle");
    applyStimulus(0, 32'h40, 0, 0, 0, 0, 0, "alloc_hit");
    repeat (3) applyStimulus(0, 32'h40, 1, 32'h40, 1, 32'h84, 1, "taken_up");
    applyStimulus(0, 32'h40, 0, 0, 0, 0, 0, "strong_taken");
    repeat (2) applyStimulus(0, 32'h40, 1, 32'h40, 0, 0, 1, "nt_down");
    applyStimulus(0, 32'h40, 0, 0, 0, 0, 0, "weak_nt");
    repeat (2) applyStimulus(0, 32'h41, 1, 32'h42, 0, 0, 0, "nt_floor");
    applyStimulus(0, 32'h40, 1, 32'h40, 1, 32'h90, 0, "from_floor");
    applyStimulus(0, 32'h40, 0, 0, 0, 0, 0, "still_nt");
    applyStimulus(0, 32'h40, 1, 32'h80, 1, 32'h100, 0, "alias_alloc");
    applyStimulus(0, 32'h40, 0, 0, 0, 0, 0, "alias_old_miss");
    applyStimulus(0, 32'h80, 1, 32'hC0, 0, 32'h200, 0, "nt_miss_c0");
    applyStimulus(0, 32'h80, 0, 0, 0, 0, 0, "alias_new_hit");
    applyStimulus(0, 32'hC0, 0, 0, 0, 0, 0, "c0_miss");
    applyStimulus(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, "wrap");
    applyStimulus(1, 32'h80, 1, 32'h80, 1, 32'h300, 0, "mid_reset");
    applyStimulus(0, 32'h80, 0, 0, 0, 0, 0, "after_reset");

    for (int n = 0; n < 3000; n++) begin
      pc   = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) pc = $urandom;
      lk   = ($urandom_range(0, 1) == 1) ? pc : ((32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2));
      if ($urandom_range(0, 49) == 0) lk = 32'hFFFF_FFFC;
      tk   = 1'($urandom_range(0, 1));
      pred = ($urandom_range(0, 9) < 7) ? modelTaken(pc) : 1'($urandom_range(0, 1));
      applyStimulus(($urandom_range(0, 299) == 0), lk, ($urandom_range(0, 3) != 0), pc, tk,
                    $urandom & 32'hFFFF_FFFC, pred, "random");
    end

    for (int n = 0; n < SATMAX + 4; n++) begin
      applyStimulus(0, 32'h200, 1, 32'h200, 1, 32'h400, 0, "stat_sat");
    end
    applyStimulus(0, 32'h200, 1, 32'h200, 1, 32'h400, 1, "correct_pred");
    applyStimulus(0, 32'h200, 0, 0, 0, 0, 0, "final");

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
